// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state encoding, read-during-write constants and byte helpers for ram_dp_be
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  // Bit that makes the 9-bit {parity, byte} group carry an even number of ones.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// rtl/ram_clear_ctrl.sv - post-reset clear sweep FSM; walks every address once and then stays READY
import ram_pkg::*;

module ram_clear_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [0:0]        S_CLEAR = 1'(CLEAR);
  localparam logic [0:0]        S_READY = 1'(READY);
  localparam logic [ADDR_W-1:0] LAST    = '1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == LAST) begin
        r_state <= S_READY;
      end
    end
  end

  // The sweep never writes while reset is held, so memory survives a long reset untouched.
  assign busy     = (r_state == S_CLEAR);
  assign clr_we   = busy && !rst;
  assign clr_addr = r_clr_cnt;

endmodule

// File: rtl/ram_dp_be.sv
// rtl/ram_dp_be.sv - simple dual-port RAM with byte enables, 1/2-cycle read latency and clear sweep
// Optional macro RAM_DP_BE_PARITY_EN adds per-byte even parity, the par_inj input and the perr output.
import ram_pkg::*;

module ram_dp_be #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
`ifdef RAM_DP_BE_PARITY_EN
  input  logic                  par_inj,
  output logic                  perr,
`endif
  output logic                  busy
);

  localparam int NB    = byte_lanes(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_DP_BE_PARITY_EN
  localparam int MEM_W = DATA_W + NB;
`else
  localparam int MEM_W = DATA_W;
`endif

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("ram_dp_be: RD_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("ram_dp_be: DATA_W must be a multiple of 8");
  end

  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [MEM_W-1:0]  r_rd_word;
  logic              r_rd_valid;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_act;
  logic              w_rd_act;
  logic [MEM_W-1:0]  w_merged;
  logic [MEM_W-1:0]  w_rd_word;

  ram_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_wr_act = wr_en && !w_busy && !rst;
  assign w_rd_act = rd_en && !w_busy && !rst;

  // One merged word serves both the memory write and the new-data bypass.
  always_comb begin
    w_merged = r_mem[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        w_merged[8*i +: 8] = wr_data[8*i +: 8];
`ifdef RAM_DP_BE_PARITY_EN
        w_merged[DATA_W+i] = even_parity(wr_data[8*i +: 8]) ^ par_inj;
`endif
      end
    end
  end

  always_comb begin
    w_rd_word = r_mem[rd_addr];
    if (RDW_MODE == RDW_NEW && w_wr_act && (wr_addr == rd_addr)) begin
      w_rd_word = w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_act) begin
      r_mem[wr_addr] <= w_merged;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [MEM_W-1:0] r_s1_word;
    logic             r_s1_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_word  <= '0;
        r_s1_valid <= 1'b0;
        r_rd_word  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_s1_valid <= w_rd_act;
        if (w_rd_act) begin
          r_s1_word <= w_rd_word;
        end
        r_rd_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rd_word <= r_s1_word;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_word  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_act;
        if (w_rd_act) begin
          r_rd_word <= w_rd_word;
        end
      end
    end
  end

  assign rd_data  = r_rd_word[DATA_W-1:0];
  assign rd_valid = r_rd_valid;
  assign busy     = w_busy;

`ifdef RAM_DP_BE_PARITY_EN
  // Checked on the registered word so perr lines up with rd_valid at either latency.
  always_comb begin
    perr = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (r_mem_check_fail(r_rd_word, i)) begin
        perr = r_rd_valid;
      end
    end
  end

  function automatic logic r_mem_check_fail(input logic [MEM_W-1:0] w, input int lane);
    return w[DATA_W+lane] ^ even_parity(w[8*lane +: 8]);
  endfunction
`endif

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
- Parametrised simple-dual-port RAM: one write port and one read port, both usable in the same cycle. Successor to the team's fixed 16x8 single-port RAM.
- Adds byte-enable writes, a configurable read latency, a defined read-during-write policy and a post-reset memory-clear sweep.
- Used as a generic storage macro for buffers and register files inside the datapath.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new (merged) data.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data is valid this cycle.
- busy  out  1  clear sweep in progress; requests are ignored.

Behaviour:
- Reset. Any posedge with rst=1 sets:
  - rd_data=0, rd_valid=0 and all pipeline stages cleared;
  - state=CLEAR, clr_cnt=0, busy=1.
  - Memory contents are not touched while rst is held.
- FSM states are CLEAR and READY.
  - CLEAR, rst=0: mem[clr_cnt] is written to all zeros and clr_cnt increments. When clr_cnt==DEPTH-1, the next state is READY.
  - busy=1 exactly DEPTH cycles after rst falls, then 0.
  - READY: stays in READY until rst.
- Reset mid-sweep or mid-read: the sweep restarts at address 0 and in-flight reads are dropped (no rd_valid).
- While busy=1: wr_en and rd_en are ignored; no memory write from the ports and no rd_valid.
- Write (READY, wr_en=1): for each i with wr_be[i]=1, byte i of mem[wr_addr] is updated at the posedge. wr_be=0 is a no-op.
- Read (READY, rd_en=1):
  - RD_LAT=1: rd_data and rd_valid appear on the first posedge after the request.
  - RD_LAT=2: they appear on the second posedge (extra output register).
  - rd_valid is a one-cycle pulse per request. Back-to-back reads give one result per cycle.
- rd_data holds its last value when rd_valid=0.
- Simultaneous wr_en and rd_en, different addresses: independent; both take effect.
- Simultaneous wr_en and rd_en, same address:
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns the merged word (enabled bytes from wr_data, the rest from memory).
- Addresses wrap naturally within ADDR_W bits; there is no out-of-range case.
- Illegal RD_LAT is rejected by an elaboration-time check.

Optional Feature:
- Macro: RAM_DP_BE_PARITY_EN.
- Defined:
  - Each stored byte carries an even-parity bit, computed on write and cleared to 0 by the sweep.
  - Extra input par_inj (1 bit): when 1 during a write, the stored parity of every written byte is inverted.
  - Extra output perr (1 bit): aligned with rd_valid; 1 if any byte of the read word fails parity, reset value 0.
  - The RDW_MODE=1 bypass path recomputes parity from the merged word, including par_inj inversion for written bytes.
- Undefined: no parity storage, no par_inj or perr ports, memory width DATA_W.

Decomposition:
- Package ram_pkg:
  - state enum {CLEAR, READY};
  - RDW_OLD=0 and RDW_NEW=1 constants;
  - a byte-lane count function (DATA_W/8);
  - an even-parity function.
- Sub-module ram_clear_ctrl: the FSM plus clr_cnt. Outputs busy, clr_we and clr_addr; the top muxes the sweep write ahead of the port write.

Test Plan:
- Reset sweep, defaults: rst high for 3 cycles then low → busy=1 for exactly 16 cycles. Then read every address → all reads return 0x00, rd_valid one pulse each.
- Byte enables, DATA_W=32: write 0xAABBCCDD to addr 5 with be=1111. Then write 0x11223344 with be=0101. Read addr 5 → 0xAA22CC44.
- Read-during-write: mem[3]=0x10; same-cycle write 0x20/be=1 and read addr 3:
  - RDW_MODE=0 → 0x10;
  - RDW_MODE=1 → 0x20;
  - a follow-up read → 0x20.
- Latency and throughput: RD_LAT=2, reads to addr 0..3 on 4 consecutive cycles → data appears on cycles 2..5 in order, rd_valid high 4 cycles.
- Mid-sweep reset: assert rst at sweep cycle 7 → busy stays high 16 more cycles after release. A write attempted while busy → address still reads 0.
- Parity (macro defined): write 0x5A with par_inj=1, then read → perr=1 with rd_valid. Rewrite with par_inj=0 → perr=0.
